// File: rtl/matrix_writer.sv
// matrix_writer: stores one parsed matrix into its BRAM block.
//
// Consumes the number stream rows m, cols n, then m*n elements row-major, and
// writes a header word {16'h0, n, m} at base = matrix_id*BLOCK_SIZE followed by
// the elements at base+1 onwards, through BRAM write port A.
//
// Optional feature macro: MATRIX_WRITER_ZERO_PAD_EN
//   defined   - a stream that ends (num_last) before m*n elements has its
//               remaining words written with 0, then completes normally.
//   undefined - such a short stream ends in an error pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, matrix_id    begin a write into block matrix_id (sampled in idle)
//   num_data/valid/last number stream in; num_ready is the accept handshake
//   bram_we/addr/wdata  registered BRAM write port
//   busy                high whenever not idle
//   done, error         one-cycle completion / failure pulses
//   rows_out, cols_out  dimensions of the last successfully written matrix
module matrix_writer #(
    parameter int unsigned BLOCK_SIZE = 1152,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned MAX_DIM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            matrix_id,
    input  logic [31:0]           num_data,
    input  logic                  num_valid,
    input  logic                  num_last,
    output logic                  num_ready,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            rows_out,
    output logic [7:0]            cols_out
);

    localparam logic [7:0]            MaxDim    = 8'(MAX_DIM);
    localparam logic [ADDR_WIDTH-1:0] BlockAddr = ADDR_WIDTH'(BLOCK_SIZE);

    typedef enum logic [3:0] {
        StIdle,
        StGetM,
        StGetN,
        StCheck,
        StWriteHdr,
        StWriteData,
        StFinish,
        StDone,
        StError,
        StPad
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [7:0]              m_q, m_d;
    logic [7:0]              n_q, n_d;
    logic                    hi_bad_q, hi_bad_d;   // upper bits of m or n were nonzero
    logic [10:0]             total_q, total_d;
    logic [10:0]             idx_q, idx_d;
    logic                    final_last_q, final_last_d; // final element carried num_last
    logic                    num_ready_q, num_ready_d;
    logic                    bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic [31:0]             bram_wdata_q, bram_wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [7:0]              rows_q, rows_d;
    logic [7:0]              cols_q, cols_d;

    logic                    xfer;
    logic                    idx_at_end;
    logic                    dims_bad;
    logic [ADDR_WIDTH-1:0]   data_addr;

    assign xfer       = num_valid && num_ready_q;
    assign idx_at_end = (idx_q == total_q - 11'd1);
    assign dims_bad   = (m_q == 8'd0) || (n_q == 8'd0) || (m_q > MaxDim) || (n_q > MaxDim) ||
                        hi_bad_q;
    assign data_addr  = base_q + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        m_d          = m_q;
        n_d          = n_q;
        hi_bad_d     = hi_bad_q;
        total_d      = total_q;
        idx_d        = idx_q;
        final_last_d = final_last_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        rows_d       = rows_q;
        cols_d       = cols_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = ADDR_WIDTH'(matrix_id) * BlockAddr;
                    state_d = StGetM;
                end
            end
            StGetM: begin
                if (xfer) begin
                    m_d      = num_data[7:0];
                    hi_bad_d = |num_data[31:8];
                    // A stream that ends on m carries no matrix at all.
                    state_d  = num_last ? StError : StGetN;
                end
            end
            StGetN: begin
                if (xfer) begin
                    n_d      = num_data[7:0];
                    hi_bad_d = hi_bad_q | (|num_data[31:8]);
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (dims_bad) begin
                    state_d = StError;
                end else begin
                    total_d = {3'b000, m_q} * {3'b000, n_q};
                    idx_d   = 11'd0;
                    state_d = StWriteHdr;
                end
            end
            StWriteHdr: begin
                bram_we_d    = 1'b1;
                bram_addr_d  = base_q;
                bram_wdata_d = {16'h0000, n_q, m_q};
                state_d      = StWriteData;
            end
            StWriteData: begin
                if (xfer) begin
                    bram_we_d    = 1'b1;
                    bram_addr_d  = data_addr;
                    bram_wdata_d = num_data;
                    idx_d        = idx_q + 11'd1;
                    if (idx_at_end) begin
                        final_last_d = num_last;
                        state_d      = StFinish;
                    end else if (num_last) begin
`ifdef MATRIX_WRITER_ZERO_PAD_EN
                        state_d = StPad;
`else
                        state_d = StError;
`endif
                    end
                end
            end
`ifdef MATRIX_WRITER_ZERO_PAD_EN
            StPad: begin
                bram_we_d    = 1'b1;
                bram_addr_d  = data_addr;
                bram_wdata_d = 32'h0;
                idx_d        = idx_q + 11'd1;
                if (idx_at_end) begin
                    // Stream already ended, so the excess check in finish must pass.
                    final_last_d = 1'b1;
                    state_d      = StFinish;
                end
            end
`endif
            StFinish: begin
                // An unflagged final element followed by more data means too many numbers.
                state_d = (!final_last_q && num_valid) ? StError : StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are registered from the next state so they line up with it.
        if (state_d == StDone) begin
            rows_d = m_q;
            cols_d = n_q;
        end
        done_d      = (state_d == StDone);
        error_d     = (state_d == StError);
        busy_d      = (state_d != StIdle);
        num_ready_d = (state_d == StGetM) || (state_d == StGetN) || (state_d == StWriteData);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            m_q          <= 8'd0;
            n_q          <= 8'd0;
            hi_bad_q     <= 1'b0;
            total_q      <= 11'd0;
            idx_q        <= 11'd0;
            final_last_q <= 1'b0;
            num_ready_q  <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= 32'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rows_q       <= 8'd0;
            cols_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            m_q          <= m_d;
            n_q          <= n_d;
            hi_bad_q     <= hi_bad_d;
            total_q      <= total_d;
            idx_q        <= idx_d;
            final_last_q <= final_last_d;
            num_ready_q  <= num_ready_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
        end
    end

    assign num_ready  = num_ready_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign rows_out   = rows_q;
    assign cols_out   = cols_q;

endmodule

// File: tb/tb_matrix_writer.sv
// Self-checking bench for matrix_writer: randomized streams checked against a
// dimension/element reference model of the expected BRAM write sequence.
module tb_matrix_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  matrix_id;
    logic [31:0] num_data;
    logic        num_valid;
    logic        num_last;
    logic        num_ready;
    logic        bram_we;
    logic [13:0] bram_addr;
    logic [31:0] bram_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  rows_out;
    logic [7:0]  cols_out;

    always #5 clk = ~clk;

    matrix_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matrix_id  (matrix_id),
        .num_data   (num_data),
        .num_valid  (num_valid),
        .num_last   (num_last),
        .num_ready  (num_ready),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .rows_out   (rows_out),
        .cols_out   (cols_out)
    );

    int checks   = 0;
    int failures = 0;

    // Write monitor: every observed write as {addr, data} with the cycle it appeared.
    logic [45:0] wq[$];
    int          wcyc[$];
    int          cyc      = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we) begin
            wq.push_back({bram_addr, bram_wdata});
            wcyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (error) err_cnt = err_cnt + 1;
    end

    // Reference model: expected writes for a stream whose last value carries num_last.
    logic [45:0] exp_q[$];
    bit          exp_ok;

    function automatic void build_expect(input int id, input logic [31:0] vals[$]);
        int base, m, n, total, k;
        exp_q.delete();
        base = id * 1152;
        m = int'(vals[0]);
        n = int'(vals[1]);
        if (m < 1 || m > 32 || n < 1 || n > 32) begin
            exp_ok = 1'b0;
            return;
        end
        exp_q.push_back({14'(base), 16'h0000, 8'(n), 8'(m)});
        total = m * n;
        k = vals.size() - 2;
        for (int i = 0; i < k && i < total; i++) exp_q.push_back({14'(base + 1 + i), vals[2 + i]});
        if (k < total) begin
`ifdef MATRIX_WRITER_ZERO_PAD_EN
            for (int i = k; i < total; i++) exp_q.push_back({14'(base + 1 + i), 32'h0});
            exp_ok = 1'b1;
`else
            exp_ok = 1'b0;
`endif
        end else begin
            exp_ok = 1'b1;
        end
    endfunction

    task automatic do_start(input logic [2:0] id);
        start     = 1'b1;
        matrix_id = id;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input bit last, input int gapmax, output bit ok);
        bit rdy;
        int g;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (g) begin
            @(posedge clk); #1;
        end
        num_data  = d;
        num_last  = last;
        num_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            rdy = num_ready;
            @(posedge clk); #1;
            ok = rdy;
        end
        num_valid = 1'b0;
        num_last  = 1'b0;
    endtask

    task automatic drive_stream(input logic [2:0] id, input logic [31:0] vals[$],
                                input int last_idx, input int gapmax, input int count);
        bit ok;
        ok = 1'b1;
        do_start(id);
        for (int i = 0; i < count && ok; i++) push(vals[i], i == last_idx, gapmax, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stream_accept: number not accepted within bound (got ready=0, want 1)");
        end
    endtask

    task automatic wait_end(output bit gd, output bit ge);
        gd = 1'b0;
        ge = 1'b0;
        for (int i = 0; i < 100 && !gd && !ge; i++) begin
            @(negedge clk);
            gd = done;
            ge = error;
        end
        @(posedge clk); #1;
        checks++;
        if (!gd && !ge) begin
            failures++;
            $display("FAIL end_pulse: no done/error within bound (got none, want one)");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; matrix_id = 3'd0;
        num_data = 32'h0; num_valid = 1'b0; num_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({num_ready, bram_we, bram_addr, bram_wdata, busy, done, error, rows_out, cols_out}
            !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d busy=%b rows=%0d want all 0",
                     num_ready, bram_we, bram_addr, busy, rows_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] v[$];
        int w0, d0, e0;
        bit gd, ge;
        v.push_back(32'd2);
        v.push_back(32'd3);
        for (int i = 1; i <= 6; i++) v.push_back(32'(i));
        build_expect(1, v);
        w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
        drive_stream(3'd1, v, 7, 0, v.size());
        wait_end(gd, ge);
        checks++;
        if (wq.size() - w0 != exp_q.size()) begin
            failures++;
            $display("FAIL basic_count: got %0d writes want %0d", wq.size() - w0, exp_q.size());
        end
        checks++;
        if (wq.size() > w0 && wq[w0] !== {14'd1152, 32'h0000_0302}) begin
            failures++;
            $display("FAIL basic_header: got %h want %h", wq[w0], {14'd1152, 32'h0000_0302});
        end
        for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
            checks++;
            if (wq[w0 + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i,
                         wq[w0 + i][45:32], wq[w0 + i][31:0], exp_q[i][45:32], exp_q[i][31:0]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            failures++;
            $display("FAIL basic_pulses: got done=%0d error=%0d want 1 0",
                     done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (rows_out !== 8'd2 || cols_out !== 8'd3) begin
            failures++;
            $display("FAIL basic_dims: got %0dx%0d want 2x3", rows_out, cols_out);
        end
        // Back-to-back elements land on consecutive cycles; done follows the last write.
        if (wq.size() >= w0 + 7) begin
            checks++;
            if (wcyc[w0 + 6] - wcyc[w0 + 1] != 5) begin
                failures++;
                $display("FAIL back_to_back: got span %0d want 5", wcyc[w0 + 6] - wcyc[w0 + 1]);
            end
            checks++;
            if (done_cyc - wcyc[w0 + 6] < 1) begin
                failures++;
                $display("FAIL done_after_write: got gap %0d want >=1", done_cyc - wcyc[w0 + 6]);
            end
        end
    endtask

    task automatic test_bad_dims();
        logic [31:0] ms[3] = '{32'd0, 32'd33, 32'h0000_0102};
        logic [31:0] ns[3] = '{32'd4, 32'd2, 32'd2};
        for (int t = 0; t < 3; t++) begin
            logic [31:0] v[$];
            int w0, d0, e0;
            bit gd, ge;
            v.push_back(ms[t]);
            v.push_back(ns[t]);
            w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
            drive_stream(3'(t), v, -1, 1, 2);
            wait_end(gd, ge);
            @(negedge clk);
            checks++;
            if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || wq.size() != w0) begin
                failures++;
                $display("FAIL bad_dims[%0d]: got error=%0d done=%0d writes=%0d want 1 0 0", t,
                         err_cnt - e0, done_cnt - d0, wq.size() - w0);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL bad_dims_busy[%0d]: got busy=%b want 0", t, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_big();
        logic [31:0] v[$];
        int w0, d0;
        bit gd, ge;
        int bad;
        v.push_back(32'd32);
        v.push_back(32'd32);
        for (int i = 0; i < 1024; i++) v.push_back($urandom);
        build_expect(7, v);
        w0 = wq.size(); d0 = done_cnt;
        drive_stream(3'd7, v, v.size() - 1, 3, v.size());
        wait_end(gd, ge);
        checks++;
        if (wq.size() - w0 != 1025) begin
            failures++;
            $display("FAIL big_count: got %0d writes want 1025", wq.size() - w0);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
            checks++;
            if (wq[w0 + i] !== exp_q[i]) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL big_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i,
                             wq[w0 + i][45:32], wq[w0 + i][31:0], exp_q[i][45:32], exp_q[i][31:0]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL big_done: got %0d done pulses want 1", done_cnt - d0);
        end
    endtask

    task automatic test_short();
        logic [31:0] v[$];
        int w0, d0, e0;
        bit gd, ge;
        v.push_back(32'd2);
        v.push_back(32'd2);
        for (int i = 0; i < 3; i++) v.push_back($urandom);
        build_expect(2, v);
        w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
        drive_stream(3'd2, v, 4, 0, v.size());
        wait_end(gd, ge);
        checks++;
        if (wq.size() - w0 != exp_q.size()) begin
            failures++;
            $display("FAIL short_count: got %0d writes want %0d", wq.size() - w0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
            checks++;
            if (wq[w0 + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL short_write[%0d]: got %h want %h", i, wq[w0 + i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt - d0 != int'(exp_ok) || err_cnt - e0 != int'(!exp_ok)) begin
            failures++;
            $display("FAIL short_outcome: got done=%0d error=%0d want done=%0d error=%0d",
                     done_cnt - d0, err_cnt - e0, exp_ok, !exp_ok);
        end
    endtask

    task automatic test_excess();
        logic [31:0] v[$];
        int w0, d0, e0;
        bit gd, ge, consumed;
        v.push_back(32'd2);
        v.push_back(32'd2);
        for (int i = 0; i < 4; i++) v.push_back($urandom);
        build_expect(4, v);
        w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
        drive_stream(3'd4, v, -1, 0, v.size());
        num_data = $urandom; num_last = 1'b1; num_valid = 1'b1;
        consumed = 1'b0; gd = 1'b0; ge = 1'b0;
        for (int i = 0; i < 10 && !gd && !ge; i++) begin
            @(negedge clk);
            if (num_ready) consumed = 1'b1;
            gd = done;
            ge = error;
        end
        @(posedge clk); #1;
        num_valid = 1'b0; num_last = 1'b0;
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL excess_outcome: got error=%0d done=%0d want 1 0",
                     err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (consumed !== 1'b0) begin
            failures++;
            $display("FAIL excess_consumed: got ready=1 for extra number want 0");
        end
        checks++;
        if (wq.size() - w0 != exp_q.size()) begin
            failures++;
            $display("FAIL excess_count: got %0d writes want %0d", wq.size() - w0, exp_q.size());
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] v[$];
        int w0, d0;
        bit ok, gd, ge;
        do_start(3'd3);
        push(32'd4, 1'b0, 0, ok);
        push(32'd4, 1'b0, 0, ok);
        for (int i = 0; i < 5; i++) push($urandom, 1'b0, 0, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({num_ready, bram_we, bram_addr, bram_wdata, busy, done, error, rows_out, cols_out}
            !== 67'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got ready=%b we=%b busy=%b rows=%0d want all 0",
                     num_ready, bram_we, busy, rows_out);
        end
        rst = 1'b0;
        w0 = wq.size(); d0 = done_cnt;
        @(posedge clk); #1;
        v.push_back(32'd2);
        v.push_back(32'd2);
        for (int i = 0; i < 4; i++) v.push_back($urandom);
        build_expect(2, v);
        drive_stream(3'd2, v, 5, 1, v.size());
        wait_end(gd, ge);
        checks++;
        if (wq.size() - w0 != exp_q.size() || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL rst_mid_rerun: got writes=%0d done=%0d want %0d 1",
                     wq.size() - w0, done_cnt - d0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
            checks++;
            if (wq[w0 + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rst_mid_write[%0d]: got %h want %h", i, wq[w0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        logic [31:0] v[$];
        int w0;
        bit ok, gd, ge;
        v.push_back(32'd2);
        v.push_back(32'd2);
        for (int i = 0; i < 4; i++) v.push_back($urandom);
        build_expect(5, v);
        w0 = wq.size();
        do_start(3'd5);
        push(v[0], 1'b0, 0, ok);
        start = 1'b1; matrix_id = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 6; i++) push(v[i], i == 5, 0, ok);
        wait_end(gd, ge);
        checks++;
        if (wq.size() - w0 != exp_q.size() || !gd) begin
            failures++;
            $display("FAIL start_busy_outcome: got writes=%0d done=%b want %0d 1",
                     wq.size() - w0, gd, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
            checks++;
            if (wq[w0 + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL start_busy_write[%0d]: got %h want %h", i, wq[w0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [31:0] v[$];
            int w0, d0, e0, id, m, n, cnt;
            bit gd, ge;
            id = int'($urandom_range(0, 7));
            m  = int'($urandom_range(1, 6));
            n  = int'($urandom_range(1, 6));
            if ($urandom_range(0, 5) == 0) m = 40;
            v.push_back(32'(m));
            v.push_back(32'(n));
            for (int i = 0; i < m * n && m <= 32; i++) v.push_back($urandom);
            build_expect(id, v);
            cnt = (exp_q.size() == 0) ? 2 : v.size();
            w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
            drive_stream(3'(id), v, cnt - 1 + ((exp_q.size() == 0) ? 1 : 0), 2, cnt);
            wait_end(gd, ge);
            checks++;
            if (wq.size() - w0 != exp_q.size() || done_cnt - d0 != int'(exp_ok) ||
                err_cnt - e0 != int'(!exp_ok)) begin
                failures++;
                $display("FAIL random[%0d] %0dx%0d: got writes=%0d done=%0d err=%0d want %0d %0d %0d",
                         t, m, n, wq.size() - w0, done_cnt - d0, err_cnt - e0, exp_q.size(),
                         exp_ok, !exp_ok);
            end
            for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
                checks++;
                if (wq[w0 + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random[%0d]_write[%0d]: got %h want %h", t, i, wq[w0 + i],
                             exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_dims();
        test_big();
        test_short();
        test_excess();
        test_rst_mid();
        test_start_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
